// File: rtl/dmem_pkg.sv
// dmem_pkg: shared data-memory arbiter op codes, limits and pointer-width helper
package dmem_pkg;
   typedef enum logic [1:0] {OP_RD = 2'd0, OP_WR = 2'd1, OP_LL = 2'd2, OP_SC = 2'd3} op_e;
   localparam int N_CORES_MAX = 8;
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/shared_dmem_arbiter_if.sv
// shared_dmem_arbiter_if: per-core request/response bus of the shared data memory
interface shared_dmem_arbiter_if #(
   parameter int N_CORES = 2,
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32
);
   logic [N_CORES-1:0]        req_valid;
   logic [2*N_CORES-1:0]      req_op;
   logic [ADDR_W*N_CORES-1:0] req_addr;
   logic [DATA_W*N_CORES-1:0] req_wdata;
   logic [N_CORES-1:0]        req_ready;
   logic [N_CORES-1:0]        rsp_valid;
   logic [DATA_W*N_CORES-1:0] rsp_rdata;
   logic [N_CORES-1:0]        rsp_sc_ok;
   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_sc_ok
   );
   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_sc_ok
   );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, search starts after the last granted index
module rr_arbiter import dmem_pkg::*; #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);
   localparam int PW = ptr_w(N);
   logic [PW-1:0] ptr_q, ptr_d, c;
   always_comb begin
      gnt = '0;
      ptr_d = ptr_q;
      c = '0;
      for (int k = N; k >= 1; k--) begin
         c = PW'((int'(ptr_q) + k) % N);
         if (req[c]) begin
            gnt = '0;
            gnt[c] = 1'b1;
            ptr_d = c;
         end
      end
   end
   always_ff @(posedge clk) ptr_q <= rst ? PW'(N - 1) : ptr_d;
endmodule

// File: rtl/shared_dmem_arbiter.sv
// shared_dmem_arbiter: N-core shared data-memory front end with LL/SC reservations and sync barrier
module shared_dmem_arbiter import dmem_pkg::*; #(
   parameter int N_CORES = 2,
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32
) (
   input  logic                clk,
   input  logic                rst,
   shared_dmem_arbiter_if.slave core,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic [N_CORES-1:0]  sync_req,
   output logic [N_CORES-1:0]  sync_release
);
   localparam int PW = ptr_w(N_CORES);
   logic [N_CORES-1:0] gnt, pend_q, pend_d, res_v_q, res_v_d, arrived_q, arrived_d;
   logic [N_CORES-1:0][ADDR_W-1:0] res_a_q, res_a_d;
   logic [N_CORES-1:0][DATA_W-1:0] rdata_q, rdata_d;
   logic [PW-1:0] gidx;
   logic [ADDR_W-1:0] addr;
   op_e op;
   logic any, sc_ok, ld_q, ld_d, sc_q, sc_d, rel_q, rel_d;

   rr_arbiter #(.N(N_CORES)) u_arb (
      .clk(clk),
      .rst(rst),
      .req(core.req_valid & {N_CORES{~rst}}),
      .gnt(gnt)
   );

   always_comb begin
      gidx = '0;
      for (int i = 0; i < N_CORES; i++) if (gnt[i]) gidx = PW'(i);
      any = |gnt;
      op = op_e'(core.req_op[2*int'(gidx) +: 2]);
      addr = core.req_addr[ADDR_W*int'(gidx) +: ADDR_W];
      sc_ok = any && op == OP_SC && res_v_q[gidx] && res_a_q[gidx] == addr;
      mem_en = any;
      mem_we = any && (op == OP_WR || sc_ok);
      mem_addr = any ? addr : '0;
      mem_wdata = any ? core.req_wdata[DATA_W*int'(gidx) +: DATA_W] : '0;
   end

   // any performed write kills every reservation on that word; own LL/SC then override
   always_comb begin
      res_v_d = res_v_q;
      res_a_d = res_a_q;
      for (int i = 0; i < N_CORES; i++) if (mem_we && res_a_q[i] == addr) res_v_d[i] = 1'b0;
      if (any && op == OP_LL) begin
         res_v_d[gidx] = 1'b1;
         res_a_d[gidx] = addr;
      end
      if (any && op == OP_SC) res_v_d[gidx] = 1'b0;
      pend_d = gnt;
      ld_d = op == OP_RD || op == OP_LL;
      sc_d = sc_ok;
      rdata_d = rdata_q;
      for (int i = 0; i < N_CORES; i++) if (pend_q[i] && ld_q) rdata_d[i] = mem_rdata;
      rel_d = !rel_q && &(arrived_q | sync_req);
      arrived_d = (rel_q || rel_d) ? '0 : arrived_q | sync_req;
   end

   assign core.req_ready = gnt;
   assign core.rsp_valid = rst ? '0 : pend_q;
   assign core.rsp_sc_ok = rst ? '0 : pend_q & {N_CORES{sc_q}};
   assign core.rsp_rdata = rst ? '0 : rdata_d;
   assign sync_release = rst ? '0 : {N_CORES{rel_q}};

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         ld_q <= 1'b0;
         sc_q <= 1'b0;
         rdata_q <= '0;
         res_v_q <= '0;
         res_a_q <= '0;
         arrived_q <= '0;
         rel_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ld_q <= ld_d;
         sc_q <= sc_d;
         rdata_q <= rdata_d;
         res_v_q <= res_v_d;
         res_a_q <= res_a_d;
         arrived_q <= arrived_d;
         rel_q <= rel_d;
      end
   end
endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// tb_shared_dmem_arbiter: directed tests with a per-cycle behavioural model of the 4-core arbiter
module tb_shared_dmem_arbiter;
   import dmem_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        v  [4];
   logic [1:0]  o  [4];
   logic [8:0]  ad [4];
   logic [31:0] wd [4];
   logic [3:0]  sreq;
   logic        mem_en, mem_we;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [3:0]  sync_release;
   logic [31:0] ram [512] = '{default: 32'h0};

   shared_dmem_arbiter_if #(.N_CORES(4), .ADDR_W(9), .DATA_W(32)) bus ();

   shared_dmem_arbiter #(.N_CORES(4), .ADDR_W(9), .DATA_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .core(bus),
      .mem_en(mem_en),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .sync_req(sreq),
      .sync_release(sync_release)
   );

   always_comb begin
      bus.req_valid = '0;
      bus.req_op = '0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      for (int i = 0; i < 4; i++) begin
         bus.req_valid[i] = v[i];
         bus.req_op[2*i +: 2] = o[i];
         bus.req_addr[9*i +: 9] = ad[i];
         bus.req_wdata[32*i +: 32] = wd[i];
      end
   end

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   int total = 0;
   int bad = 0;
   function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
      end
   endfunction

   // behavioural model: last granted core, reservation address per core (-1 = none), memory image
   int          last_g = 3;
   int          pend_c = -1;
   bit          pend_ld, pend_sc, relp;
   logic [31:0] pend_data;
   int          res_a [4] = '{-1, -1, -1, -1};
   logic [31:0] ref_mem [512] = '{default: 32'h0};
   logic [31:0] held [4];
   bit          held_ok [4];
   logic [3:0]  arr = '0;
   int          glog [$];

   always @(negedge clk) begin
      int g, a, c;
      logic [1:0] op_g;
      bit we;
      logic [3:0] ev, es;
      if (rst) begin
         chk("rst_ready", bus.req_ready, 0);
         chk("rst_rsp_valid", bus.rsp_valid, 0);
         chk("rst_sc_ok", bus.rsp_sc_ok, 0);
         chk("rst_rdata", bus.rsp_rdata, 0);
         chk("rst_mem_en", mem_en, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_release", sync_release, 0);
         last_g = 3;
         pend_c = -1;
         relp = 0;
         arr = '0;
         for (int i = 0; i < 4; i++) begin
            res_a[i] = -1;
            held_ok[i] = 0;
         end
      end else begin
         ev = '0;
         es = '0;
         if (pend_c >= 0) begin
            ev[pend_c] = 1'b1;
            es[pend_c] = pend_sc;
            if (pend_ld) held[pend_c] = pend_data;
            held_ok[pend_c] = pend_ld;
         end
         chk("rsp_valid", bus.rsp_valid, ev);
         chk("rsp_sc_ok", bus.rsp_sc_ok, es);
         for (int i = 0; i < 4; i++) if (held_ok[i]) chk("rsp_rdata", bus.rsp_rdata[32*i +: 32], held[i]);
         g = -1;
         for (int k = 1; k <= 4; k++) begin
            c = (last_g + k) % 4;
            if (g < 0 && v[c]) g = c;
         end
         chk("req_ready", bus.req_ready, g < 0 ? 4'b0 : 4'(1 << g));
         chk("mem_en", mem_en, g >= 0);
         if (g >= 0) begin
            a = int'(ad[g]);
            op_g = o[g];
            we = op_g == OP_WR || (op_g == OP_SC && res_a[g] == a);
            chk("mem_we", mem_we, we);
            chk("mem_addr", mem_addr, a);
            chk("mem_wdata", mem_wdata, wd[g]);
            glog.push_back(g);
            pend_ld = op_g == OP_RD || op_g == OP_LL;
            pend_sc = op_g == OP_SC && we;
            pend_data = ref_mem[a];
            if (we) begin
               ref_mem[a] = wd[g];
               for (int i = 0; i < 4; i++) if (res_a[i] == a) res_a[i] = -1;
            end
            if (op_g == OP_LL) res_a[g] = a;
            if (op_g == OP_SC) res_a[g] = -1;
            last_g = g;
         end else begin
            chk("mem_we_idle", mem_we, 0);
         end
         pend_c = g;
         chk("sync_release", sync_release, relp ? 4'hF : 4'h0);
         if (relp) begin
            relp = 0;
            arr = '0;
         end else begin
            arr = arr | sreq;
            if (arr == 4'hF) begin
               relp = 1;
               arr = '0;
            end
         end
      end
   end

   task automatic issue(input int c, input logic [1:0] op_i, input int a, input logic [31:0] d,
                        output logic [31:0] rd, output logic ok, output logic we);
      int n = 0;
      @(posedge clk);
      #1;
      v[c] = 1'b1;
      o[c] = op_i;
      ad[c] = a[8:0];
      wd[c] = d;
      @(negedge clk);
      while (!bus.req_ready[c] && n < 200) begin
         @(negedge clk);
         n++;
      end
      we = mem_we;
      rd = '0;
      ok = 1'b0;
      if (!bus.req_ready[c]) begin
         chk("grant_timeout", bus.req_ready[c], 1);
         @(posedge clk);
         #1;
         v[c] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      v[c] = 1'b0;
      @(negedge clk);
      rd = bus.rsp_rdata[32*c +: 32];
      ok = bus.rsp_sc_ok[c];
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic incr_loop(input int c, output int done);
      logic [31:0] rd, rd2;
      logic ok, we;
      int tries = 0;
      done = 0;
      while (done < 1000 && tries < 5000) begin
         issue(c, OP_LL, 5, 32'h0, rd, ok, we);
         issue(c, OP_SC, 5, rd + 32'd1, rd2, ok, we);
         tries++;
         if (ok) done++;
      end
   endtask

   task automatic barrier_test();
      int rel_cnt = 0;
      int rel_at = -1;
      logic [3:0] rel_bits = '0;
      bit seen = 0;
      for (int t = 0; t < 24; t++) begin
         @(posedge clk);
         #1;
         if (seen) begin
            sreq = '0;
            seen = 0;
         end
         if (t == 3) sreq[0] = 1'b1;
         if (t == 7) sreq[1] = 1'b1;
         if (t == 8) sreq[2] = 1'b1;
         if (t == 12) sreq[3] = 1'b1;
         if (t >= 16 && t < 20) sreq[3] = 1'b1;
         if (t == 20) sreq[3] = 1'b0;
         @(negedge clk);
         if (|sync_release) begin
            rel_cnt++;
            rel_at = t;
            rel_bits = sync_release;
            seen = 1;
         end
      end
      chk("bar_count", rel_cnt, 1);
      chk("bar_cycle", rel_at, 13);
      chk("bar_bits", rel_bits, 4'hF);
   endtask

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exhausted");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r0, r1, r2, r3;
      logic k0, k1, k2, k3, w0, w1, w2, w3;
      int d0, d1;
      for (int i = 0; i < 4; i++) begin
         v[i] = 1'b0;
         o[i] = 2'd0;
         ad[i] = '0;
         wd[i] = '0;
      end
      sreq = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      issue(0, OP_WR, 5, 32'h2A, r0, k0, w0);
      chk("wr_we", w0, 1);
      issue(0, OP_RD, 5, 32'h0, r0, k0, w0);
      chk("rd_we", w0, 0);
      chk("rd_data", r0, 32'h2A);
      issue(3, OP_WR, 511, 32'hDEADBEEF, r3, k3, w3);
      issue(3, OP_RD, 511, 32'h0, r3, k3, w3);
      chk("top_addr_data", r3, 32'hDEADBEEF);

      do_reset();
      glog.delete();
      fork
         begin
            repeat (3) issue(0, OP_RD, 5, 32'h0, r0, k0, w0);
         end
         begin
            repeat (3) issue(1, OP_RD, 5, 32'h0, r1, k1, w1);
         end
      join
      chk("alt_len", glog.size(), 6);
      for (int i = 0; i < glog.size() && i < 6; i++) chk("alt_order", glog[i], i % 2);
      chk("alt_rdata", r1, 32'h2A);

      glog.delete();
      fork
         issue(0, OP_RD, 511, 32'h0, r0, k0, w0);
         issue(1, OP_RD, 5, 32'h0, r1, k1, w1);
         issue(2, OP_RD, 5, 32'h0, r2, k2, w2);
         issue(3, OP_RD, 511, 32'h0, r3, k3, w3);
      join
      chk("rot_len", glog.size(), 4);
      if (glog.size() == 4) begin
         chk("rot_0", glog[0], 2);
         chk("rot_1", glog[1], 3);
         chk("rot_2", glog[2], 0);
         chk("rot_3", glog[3], 1);
      end

      issue(0, OP_LL, 5, 32'h0, r0, k0, w0);
      chk("ll_data", r0, 32'h2A);
      issue(1, OP_WR, 5, 32'd7, r1, k1, w1);
      issue(0, OP_SC, 5, 32'd9, r0, k0, w0);
      chk("sc_broken_ok", k0, 0);
      chk("sc_broken_we", w0, 0);
      chk("sc_broken_mem", ram[5], 32'd7);
      issue(0, OP_LL, 5, 32'h0, r0, k0, w0);
      chk("ll2_data", r0, 32'd7);
      issue(0, OP_SC, 5, 32'd9, r0, k0, w0);
      chk("sc_good_ok", k0, 1);
      chk("sc_good_we", w0, 1);
      chk("sc_good_mem", ram[5], 32'd9);
      issue(1, OP_LL, 6, 32'h0, r1, k1, w1);
      issue(1, OP_SC, 5, 32'd3, r1, k1, w1);
      chk("sc_addr_ok", k1, 0);
      chk("sc_addr_mem", ram[5], 32'd9);

      issue(0, OP_WR, 5, 32'd0, r0, k0, w0);
      fork
         incr_loop(0, d0);
         incr_loop(1, d1);
      join
      chk("inc_core0", d0, 1000);
      chk("inc_core1", d1, 1000);
      chk("inc_mem", ram[5], 32'd2000);

      barrier_test();

      @(posedge clk);
      #1;
      v[0] = 1'b1;
      o[0] = OP_LL;
      ad[0] = 9'd5;
      @(negedge clk);
      chk("rl_grant", bus.req_ready, 4'b0001);
      @(posedge clk);
      #1;
      rst = 1'b1;
      v[0] = 1'b0;
      @(negedge clk);
      chk("rl_no_rsp", bus.rsp_valid, 4'b0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      v[0] = 1'b1;
      o[0] = OP_SC;
      ad[0] = 9'd5;
      wd[0] = 32'd77;
      v[1] = 1'b1;
      o[1] = OP_RD;
      ad[1] = 9'd5;
      @(negedge clk);
      chk("rl_ptr", bus.req_ready, 4'b0001);
      chk("rl_sc_we", mem_we, 0);
      @(posedge clk);
      #1;
      v[0] = 1'b0;
      @(negedge clk);
      chk("rl_sc_rsp", bus.rsp_valid[0], 1);
      chk("rl_sc_ok", bus.rsp_sc_ok[0], 0);
      @(posedge clk);
      #1;
      v[1] = 1'b0;
      @(negedge clk);
      chk("rl_rd_data", bus.rsp_rdata[63:32], 32'd2000);
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/shared_dmem_arbiter.md
Name: shared_dmem_arbiter

Overview:
- N-core front end to the single shared data memory of the multi-core processor; generalises the dual-core memory path to a parametrised core count.
- Arbitrates per-core load/store requests round-robin, one memory access per cycle.
- Adds load-linked/store-conditional (LL/SC) reservations so that read-modify-write loops on shared words are atomic.
- Adds a hardware barrier that implements the sync instruction across all cores.

Parameters:
- N_CORES, 2, number of requesting cores (2..8)
- ADDR_W, 9, word-address width (512-word data memory)
- DATA_W, 32, data word width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  N_CORES  per-core request valid
- req_op  in  2*N_CORES  per-core op: 0 RD, 1 WR, 2 LL, 3 SC
- req_addr  in  ADDR_W*N_CORES  per-core word address
- req_wdata  in  DATA_W*N_CORES  per-core store data
- req_ready  out  N_CORES  one-hot grant; request accepted this cycle
- rsp_valid  out  N_CORES  response strobe, one cycle after grant
- rsp_rdata  out  DATA_W*N_CORES  load data (RD/LL)
- rsp_sc_ok  out  N_CORES  SC success flag, valid with rsp_valid
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency
- sync_req  in  N_CORES  core waiting at barrier (level)
- sync_release  out  N_CORES  barrier release pulse

Behaviour:
- Reset (synchronous, active-high): all outputs 0; rr pointer = N_CORES-1, so core 0 has first priority; all reservations invalid; barrier arrival bitmap cleared; pending response dropped.
- Handshake:
  - A core holds req_valid and its fields stable until req_ready.
  - A core issues at most one request, then waits for its rsp_valid before issuing the next.
- Arbitration:
  - Each cycle, grant the first valid core searching from pointer+1 (mod N_CORES).
  - On grant, pointer = granted index.
  - No valid request: no grant, pointer unchanged.
- Grant cycle T drives the memory port combinationally from the granted request: mem_en=1, mem_addr=addr, mem_wdata=wdata.
  - mem_we=1 for WR, or for SC with a valid matching reservation; otherwise 0.
- Cycle T+1: rsp_valid[i]=1 for exactly one cycle.
  - RD/LL: rsp_rdata[i]=mem_rdata.
  - WR: rsp_rdata don't-care.
  - rsp_rdata[i] holds its value until the next response to that core.
- Back-to-back grants to different cores every cycle are allowed (pipelined); throughput is 1 access/cycle.
- Reservations (per core: valid bit plus address):
  - LL grant: set own valid, latch addr.
  - SC grant: succeeds iff own valid and address matches. Success writes memory and sets rsp_sc_ok=1; failure skips the write and sets rsp_sc_ok=0. Own reservation is cleared in both cases.
  - Any performed write (WR or successful SC) to address A clears every core's reservation on A, including other cores'.
  - Only one access per cycle, so there are no simultaneous-write conflicts.
- Barrier:
  - arrived[i] is set while sync_req[i]=1.
  - When arrived is all ones, the next cycle pulses sync_release to all cores for 1 cycle and clears arrived.
  - sync_req is ignored during the release cycle. Cores drop sync_req on seeing the release.
  - The barrier is independent of memory arbitration; both can be active in the same cycle.
- Address/width rules:
  - Word addresses wrap mod 2^ADDR_W.
  - No byte-alignment handling here; the core converts byte addresses to word addresses.

Decomposition:
- Package dmem_pkg: req_op encodings (OP_RD, OP_WR, OP_LL, OP_SC), N_CORES_MAX=8, helper for the clog2 pointer width.
- Sub-module rr_arbiter (N inputs, one-hot grant, rotating pointer); reservation table and barrier stay in the top module.

Test Plan:
- Single core, WR addr 5 = 0x2A, then RD addr 5 -> mem_we pulse in WR grant cycle; RD rsp_valid one cycle after its grant with rdata 0x2A.
- Both cores assert RD every cycle for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; no starvation; each rsp_valid lands on the cycle after its own grant.
- Core0 LL addr 5, core1 WR addr 5 = 7, core0 SC addr 5 = 9 -> SC rsp_sc_ok=0; memory still 7; no mem_we on the SC.
- Both cores run LL/addi/SC retry loops, 1000 increments each, on addr 5 initialised to 0 -> final memory[5] = 2000.
- N_CORES=4: cores assert sync_req at cycles 3, 7, 8, 12 -> sync_release pulses on all four cores at cycle 13 only; arrived cleared.
- rst asserted in the cycle after an LL grant -> no rsp_valid; reservation invalid; a subsequent SC returns rsp_sc_ok=0; pointer restarts at core 0.
